// File: rtl/stfq_rank_pkg.sv
// Shared constants for the rank pipe: scheduling modes, default widths and FIFO sizing.
package stfq_rank_pkg;

  localparam int MODE_RR   = 0;
  localparam int MODE_STFQ = 1;

  localparam int DFLT_FLOW_ID_WIDTH = 16;
  localparam int DFLT_RANK_WIDTH    = 32;
  localparam int DFLT_META_WIDTH    = 16;

  function automatic int fifo_depth(input int l2_depth);
    return 1 << l2_depth;
  endfunction

endpackage

// File: rtl/stfq_rank_fifo.sv
// Small first-word-fallthrough FIFO: head entry visible on dout while not empty.
// Latency 1 (write at edge N, visible after N); writes when full and reads when empty are ignored.
module fallthrough_small_fifo
  import stfq_rank_pkg::*;
#(
  parameter int WIDTH          = 48,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        din,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [MAX_DEPTH_BITS:0] count
);

  localparam int DEPTH = fifo_depth(MAX_DEPTH_BITS);
  localparam int CW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic                      do_wr;
  logic                      do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr];

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stfq_rank.sv
// Per-flow STFQ / round-robin rank tagger buffering {rank,meta} in order; vtime advances on removal.
// Latency 2 insert-to-valid_out; busy advises at 2^L2_DEPTH-1 incl. in-flight, inserts into a full FIFO drop.
module stfq_rank
  import stfq_rank_pkg::*;
#(
  parameter int FLOW_ID_WIDTH = DFLT_FLOW_ID_WIDTH,
  parameter int MAX_NUM_FLOWS = 16,
  parameter int RANK_WIDTH    = DFLT_RANK_WIDTH,
  parameter int META_WIDTH    = DFLT_META_WIDTH,
  parameter int LEN_WIDTH     = 16,
  parameter int COST_WIDTH    = 8,
  parameter int L2_DEPTH      = 4,
  parameter int MODE          = MODE_STFQ
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  input  logic                     insert,
  input  logic [FLOW_ID_WIDTH-1:0] flowID_in,
  input  logic [LEN_WIDTH-1:0]     len_in,
  input  logic [META_WIDTH-1:0]    meta_in,
  input  logic                     remove,
  output logic                     valid_out,
  output logic [RANK_WIDTH-1:0]    rank_out,
  output logic [META_WIDTH-1:0]    meta_out,
  input  logic                     cfg_wr,
  input  logic [FLOW_ID_WIDTH-1:0] cfg_flow,
  input  logic [COST_WIDTH-1:0]    cfg_cost,
  output logic                     drop_out,
  output logic                     sat_out,
  output logic [RANK_WIDTH-1:0]    vtime_out
);

  localparam int DEPTH  = fifo_depth(L2_DEPTH);
  localparam int CW     = L2_DEPTH + 1;
  localparam int FIDX_W = (MAX_NUM_FLOWS > 1) ? $clog2(MAX_NUM_FLOWS) : 1;
  localparam int PROD_W = LEN_WIDTH + COST_WIDTH;
  localparam int SUM_W  = ((RANK_WIDTH > PROD_W) ? RANK_WIDTH : PROD_W) + 1;
  localparam logic [RANK_WIDTH-1:0] RANK_MAX = '1;

  typedef struct packed {
    logic [RANK_WIDTH-1:0] rank;
    logic [META_WIDTH-1:0] meta;
  } entry_t;

  logic                     s0_vld;
  logic [FLOW_ID_WIDTH-1:0] s0_flow;
  logic [LEN_WIDTH-1:0]     s0_len;
  logic [META_WIDTH-1:0]    s0_meta;

  logic [RANK_WIDTH-1:0]    vtime;
  logic [RANK_WIDTH-1:0]    finish [MAX_NUM_FLOWS];
  logic [COST_WIDTH-1:0]    cost   [MAX_NUM_FLOWS];

  logic                     s0_legal;
  logic [FIDX_W-1:0]        s0_idx;
  logic [RANK_WIDTH-1:0]    s1_start;
  logic [PROD_W-1:0]        s1_incr;
  logic [SUM_W-1:0]         s1_sum;
  logic                     s1_sat;
  logic [RANK_WIDTH-1:0]    s1_finish;
  logic                     s1_wr;

  logic                     fifo_empty;
  logic                     fifo_full;
  logic [CW-1:0]            fifo_cnt;
  logic                     pop;
  entry_t                   wr_ent;
  entry_t                   head_ent;

  // S0: register the descriptor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld  <= 1'b0;
      s0_flow <= '0;
      s0_len  <= '0;
      s0_meta <= '0;
    end else begin
      s0_vld  <= insert;
      s0_flow <= flowID_in;
      s0_len  <= len_in;
      s0_meta <= meta_in;
    end
  end

  assign s0_legal = (s0_flow < FLOW_ID_WIDTH'(MAX_NUM_FLOWS));
  assign s0_idx   = s0_flow[FIDX_W-1:0];

  // S1: finish[] is written at the end of this cycle, so a back-to-back
  // insert of the same flow reads the updated tag with no bypass needed.
  always_comb begin
    s1_start  = (finish[s0_idx] > vtime) ? finish[s0_idx] : vtime;
    s1_incr   = (MODE == MODE_RR) ? PROD_W'(1)
                                  : PROD_W'(s0_len) * PROD_W'(cost[s0_idx]);
    s1_sum    = SUM_W'(s1_start) + SUM_W'(s1_incr);
    s1_sat    = (s1_sum > SUM_W'(RANK_MAX));
    s1_finish = s1_sat ? RANK_MAX : s1_sum[RANK_WIDTH-1:0];
  end

  assign s1_wr    = s0_vld & s0_legal & ~fifo_full;
  assign drop_out = s0_vld & (~s0_legal | fifo_full);
  assign pop      = remove & ~fifo_empty;
  assign wr_ent   = '{rank: s1_start, meta: s0_meta};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vtime   <= '0;
      sat_out <= 1'b0;
      for (int f = 0; f < MAX_NUM_FLOWS; f++) begin
        finish[f] <= '0;
        cost[f]   <= COST_WIDTH'(1);
      end
    end else begin
      if (s1_wr) begin
        finish[s0_idx] <= s1_finish;
        if (s1_sat) sat_out <= 1'b1;
      end
      if (pop && (head_ent.rank > vtime)) vtime <= head_ent.rank;
      if (cfg_wr && (cfg_flow < FLOW_ID_WIDTH'(MAX_NUM_FLOWS)))
        cost[cfg_flow[FIDX_W-1:0]] <= (cfg_cost == '0) ? COST_WIDTH'(1) : cfg_cost;
    end
  end

  fallthrough_small_fifo #(
    .WIDTH          (RANK_WIDTH + META_WIDTH),
    .MAX_DEPTH_BITS (L2_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (s1_wr),
    .din   (wr_ent),
    .rd_en (pop),
    .dout  (head_ent),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  assign valid_out = ~fifo_empty;
  assign rank_out  = valid_out ? head_ent.rank : '0;
  assign meta_out  = valid_out ? head_ent.meta : '0;
  assign vtime_out = vtime;
  assign busy      = ((fifo_cnt + CW'(s0_vld)) >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_stfq_rank.sv
// Bench: STFQ and round-robin instances share stimulus; a queue-based reference model predicts every output.
module tb_stfq_rank;

  typedef struct packed {
    logic [15:0] r0;    // round-robin rank
    logic [15:0] r1;    // STFQ rank
    logic [15:0] meta;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        insert, remove, cfg_wr;
  logic [15:0] flow_id, len, meta, cfg_flow;
  logic [7:0]  cfg_cost;

  logic        s_busy, s_valid, s_drop, s_sat;
  logic [15:0] s_rank, s_meta, s_vtime;
  logic        r_busy, r_valid, r_drop, r_sat;
  logic [15:0] r_rank, r_meta, r_vtime;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (index 0 = round robin, 1 = STFQ).
  longint unsigned mv [2];
  longint unsigned mf [2][16];
  longint unsigned mc [16];
  bit              msat [2];
  ent_t            mq [$];
  bit              pend_vld;
  int              pend_flow;
  longint unsigned pend_len;
  logic [15:0]     pend_meta;

  stfq_rank #(.RANK_WIDTH(16), .MODE(1)) u_stfq (
    .clk(clk), .rst(rst), .busy(s_busy), .insert(insert), .flowID_in(flow_id),
    .len_in(len), .meta_in(meta), .remove(remove), .valid_out(s_valid),
    .rank_out(s_rank), .meta_out(s_meta), .cfg_wr(cfg_wr), .cfg_flow(cfg_flow),
    .cfg_cost(cfg_cost), .drop_out(s_drop), .sat_out(s_sat), .vtime_out(s_vtime)
  );

  stfq_rank #(.RANK_WIDTH(16), .MODE(0)) u_rr (
    .clk(clk), .rst(rst), .busy(r_busy), .insert(insert), .flowID_in(flow_id),
    .len_in(len), .meta_in(meta), .remove(remove), .valid_out(r_valid),
    .rank_out(r_rank), .meta_out(r_meta), .cfg_wr(cfg_wr), .cfg_flow(cfg_flow),
    .cfg_cost(cfg_cost), .drop_out(r_drop), .sat_out(r_sat), .vtime_out(r_vtime)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0;
      msat[k] = 0;
      for (int f = 0; f < 16; f++) mf[k][f] = 0;
    end
    for (int f = 0; f < 16; f++) mc[f] = 1;
    mq.delete();
    pend_vld = 0;
    pend_flow = 0;
    pend_len = 0;
    pend_meta = '0;
  endtask

  task automatic model_edge(input logic i, input logic [15:0] f, input logic [15:0] l,
                            input logic [15:0] m, input logic r, input logic cw,
                            input logic [15:0] cf, input logic [7:0] cc);
    ent_t e;
    ent_t h;
    bit wr;
    longint unsigned st, fin, inc;
    e = '0;
    wr = pend_vld && (pend_flow < 16) && (mq.size() < 16);
    if (wr) begin
      for (int k = 0; k < 2; k++) begin
        st  = (mf[k][pend_flow] > mv[k]) ? mf[k][pend_flow] : mv[k];
        inc = (k == 0) ? 1 : pend_len * mc[pend_flow];
        fin = st + inc;
        if (fin > 65535) begin
          fin = 65535;
          msat[k] = 1;
        end
        mf[k][pend_flow] = fin;
        if (k == 0) e.r0 = st[15:0];
        else        e.r1 = st[15:0];
      end
      e.meta = pend_meta;
    end
    if (r && (mq.size() > 0)) begin
      h = mq.pop_front();
      if (h.r0 > mv[0]) mv[0] = h.r0;
      if (h.r1 > mv[1]) mv[1] = h.r1;
    end
    if (wr) mq.push_back(e);
    if (cw && (cf < 16)) mc[cf] = (cc == 0) ? 1 : cc;
    pend_vld  = i;
    pend_flow = f;
    pend_len  = l;
    pend_meta = m;
  endtask

  task automatic check_outputs();
    bit v;
    bit b;
    bit d;
    logic [15:0] er0, er1, em;
    v = (mq.size() > 0);
    b = ((mq.size() + pend_vld) >= 15);
    d = pend_vld && ((pend_flow >= 16) || (mq.size() == 16));
    er0 = '0; er1 = '0; em = '0;
    if (v) begin
      er0 = mq[0].r0;
      er1 = mq[0].r1;
      em  = mq[0].meta;
    end
    chk("s_valid", s_valid, v);   chk("r_valid", r_valid, v);
    chk("s_busy", s_busy, b);     chk("r_busy", r_busy, b);
    chk("s_drop", s_drop, d);     chk("r_drop", r_drop, d);
    chk("s_rank", s_rank, er1);   chk("r_rank", r_rank, er0);
    chk("s_meta", s_meta, em);    chk("r_meta", r_meta, em);
    chk("s_vtime", s_vtime, mv[1]); chk("r_vtime", r_vtime, mv[0]);
    chk("s_sat", s_sat, msat[1]); chk("r_sat", r_sat, msat[0]);
  endtask

  // Drive one cycle's inputs, check current outputs, then advance the model past the next edge.
  task automatic apply(input logic i, input logic [15:0] f, input logic [15:0] l,
                       input logic [15:0] m, input logic r, input logic cw,
                       input logic [15:0] cf, input logic [7:0] cc);
    insert = i; flow_id = f; len = l; meta = m; remove = r;
    cfg_wr = cw; cfg_flow = cf; cfg_cost = cc;
    check_outputs();
    model_edge(i, f, l, m, r, cw, cf, cc);
  endtask

  task automatic tick(input logic i, input logic [15:0] f, input logic [15:0] l,
                      input logic [15:0] m, input logic r);
    @(negedge clk); #1;
    apply(i, f, l, m, r, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic cfg(input logic [15:0] f, input logic [7:0] c);
    @(negedge clk); #1;
    apply(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, f, c);
  endtask

  // Check head ranks against fixed values (negative = skip), then pop.
  task automatic pop_chk(input string tag, input int es, input int er);
    @(negedge clk); #1;
    if (es >= 0) chk({tag, "_stfq"}, s_rank, es);
    if (er >= 0) chk({tag, "_rr"}, r_rank, er);
    apply(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    insert = 0; remove = 0; cfg_wr = 0; flow_id = 0; len = 0; meta = 0;
    cfg_flow = 0; cfg_cost = 0;
    rst = 1'b0;
    model_reset();
    @(negedge clk); #1;
    check_outputs();
    rst = 1'b1;
  endtask

  initial begin
    int pops;
    int s_exp [6];
    int r_exp [6];
    rst = 1'b0;
    insert = 0; remove = 0; cfg_wr = 0; flow_id = 0; len = 0; meta = 0;
    cfg_flow = 0; cfg_cost = 0;
    model_reset();
    @(negedge clk); #1;
    chk("rst_valid", s_valid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_vtime", s_vtime, 0);
    check_outputs();
    rst = 1'b1;

    // Equal costs: two flows interleave.
    tick(1, 16'd0, 16'd100, 16'h11, 0);
    tick(1, 16'd1, 16'd100, 16'h22, 0);
    tick(1, 16'd0, 16'd100, 16'h33, 0);
    pop_chk("t1_head0", 0, 0);
    pop_chk("t1_head1", 0, 0);
    pop_chk("t1_head2", 100, 1);
    @(negedge clk); #1;
    chk("t1_vtime_stfq", s_vtime, 100);
    chk("t1_vtime_rr", r_vtime, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0);

    // Weighted cost, back-to-back same flow; cost 0 is written as 1.
    do_reset();
    cfg(16'd1, 8'd2);
    cfg(16'd2, 8'd0);
    tick(1, 16'd0, 16'd50, 16'h1, 0);
    tick(1, 16'd0, 16'd50, 16'h2, 0);
    tick(1, 16'd1, 16'd50, 16'h3, 0);
    tick(1, 16'd1, 16'd50, 16'h4, 0);
    tick(1, 16'd2, 16'd30, 16'h5, 0);
    tick(1, 16'd2, 16'd30, 16'h6, 0);
    s_exp = '{0, 50, 0, 100, 0, 30};
    r_exp = '{0, 1, 0, 1, 0, 1};
    for (int k = 0; k < 6; k++) pop_chk($sformatf("t2_head%0d", k), s_exp[k], r_exp[k]);
    @(negedge clk); #1;
    chk("t2_vtime_stfq", s_vtime, 100);
    apply(0, 0, 0, 0, 0, 0, 0, 0);

    // Round robin ignores length.
    do_reset();
    tick(1, 16'd0, 16'($urandom), 16'h1, 0);
    tick(1, 16'd0, 16'($urandom), 16'h2, 0);
    tick(1, 16'd1, 16'($urandom), 16'h3, 0);
    tick(1, 16'd2, 16'($urandom), 16'h4, 0);
    tick(1, 16'd0, 16'($urandom), 16'h5, 0);
    idle(1);
    r_exp[0] = 0; r_exp[1] = 1; r_exp[2] = 0; r_exp[3] = 0; r_exp[4] = 2;
    for (int k = 0; k < 5; k++) pop_chk($sformatf("t3_head%0d", k), -1, r_exp[k]);

    // Fill past capacity ignoring busy.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk); #1;
      if (k == 15) chk("t4_busy_at14", s_busy, 0);
      if (k == 16) chk("t4_busy_at15", s_busy, 1);
      apply(1, 16'(k % 16), 16'd1, 16'(k), 0, 0, 0, 0);
    end
    @(negedge clk); #1;
    chk("t4_drop17", s_drop, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    pops = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (s_valid) pops++;
      apply(0, 0, 0, 0, 1, 0, 0, 0);
    end
    chk("t4_held", pops, 16);

    // Illegal flow, then insert+remove in the same cycle, then remove on empty.
    do_reset();
    cfg(16'd16, 8'd9);
    tick(1, 16'd16, 16'd5, 16'h7, 0);
    @(negedge clk); #1;
    chk("t5_drop_illegal", s_drop, 1);
    chk("t5_no_valid", s_valid, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 16'd2, 16'd5, 16'h8, 0);
    idle(2);
    for (int k = 0; k < 6; k++) tick(1, 16'd2, 16'd5, 16'(k), 1);
    idle(1);
    @(negedge clk); #1;
    chk("t5_one_left", s_valid, 1);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    tick(0, 16'd0, 16'd0, 16'd0, 1);
    tick(0, 16'd0, 16'd0, 16'd0, 1);

    // Saturation, then asynchronous reset mid-run.
    do_reset();
    cfg(16'd3, 8'hFF);
    tick(1, 16'd3, 16'hFFFF, 16'h1, 0);
    tick(1, 16'd3, 16'hFFFF, 16'h2, 0);
    idle(2);
    @(negedge clk); #1;
    chk("t6_sat_stfq", s_sat, 1);
    chk("t6_sat_rr", r_sat, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    pop_chk("t6_head0", 0, 0);
    pop_chk("t6_head1", 65535, 1);
    idle(3);
    @(negedge clk); #1;
    chk("t6_sat_sticky", s_sat, 1);
    chk("t6_vtime_max", s_vtime, 65535);
    apply(1, 16'd1, 16'd4, 16'h9, 0, 0, 0, 0);
    tick(1, 16'd2, 16'd4, 16'hA, 0);
    tick(0, 16'd0, 16'd0, 16'd0, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    insert = 0; remove = 0; cfg_wr = 0;
    #1;
    chk("t6_arst_valid", s_valid, 0);
    chk("t6_arst_rank", s_rank, 0);
    chk("t6_arst_meta", s_meta, 0);
    chk("t6_arst_vtime", s_vtime, 0);
    chk("t6_arst_sat", s_sat, 0);
    chk("t6_arst_busy", s_busy, 0);
    chk("t6_arst_drop", s_drop, 0);
    model_reset();
    @(negedge clk); #1;
    check_outputs();
    rst = 1'b1;

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit do_ins;
      bit cw;
      do_ins = ($urandom_range(0, 9) < 6) &&
               (((mq.size() + pend_vld) < 15) || ($urandom_range(0, 9) == 0));
      cw = ($urandom_range(0, 19) == 0);
      @(negedge clk); #1;
      apply(do_ins, 16'($urandom_range(0, 17)), 16'($urandom_range(0, 63)),
            16'($urandom), 1'($urandom_range(0, 1)), cw,
            16'($urandom_range(0, 17)), 8'($urandom_range(0, 3)));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
